// File: rtl/mips_loader_monitor.sv
// Program loader and run supervisor for the pipelined MIPS32 core: streams an image
// into memory, initialises registers, runs the core to HALT and reads back a result.
module mips_loader_monitor #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 10,
    parameter int NREG          = 32,
    parameter int REG_INIT_MODE = 1,
    parameter int RESULT_ADDR   = 198,
    parameter int TIMEOUT       = 4096
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_we,
    output logic [4:0]        reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              core_pc_rst,
    output logic              core_run,
    input  logic              core_halted,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              timeout_err,
    output logic [31:0]       cycles
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REGINIT = 3'd1,
        S_ARM     = 3'd2,
        S_RUN     = 3'd3,
        S_READ_A  = 3'd4,
        S_READ_D  = 3'd5,
        S_DONE    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    localparam logic [4:0]        LAST_REG = 5'(NREG - 1);
    localparam logic [31:0]       TMO_CNT  = 32'(TIMEOUT);
    localparam logic [ADDR_W-1:0] RES_ADDR = ADDR_W'(RESULT_ADDR);

    state_t              state_r, state_nxt_s;
    logic                loaded_r;
    logic                accept_s, idle_like_s, start_ok_s;
    logic [31:0]         cycles_inc_s;
    logic [4:0]          reg_addr_nxt_s;
    logic                ld_ready_r, mem_we_r, reg_we_r, core_pc_rst_r, core_run_r;
    logic                busy_r, result_valid_r, timeout_err_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r, reg_wdata_r, result_r;
    logic [4:0]          reg_addr_r;
    logic [31:0]         cycles_r;

    // Handshake, start qualification and next-state decode
    always_comb begin
        accept_s     = ld_valid & ld_ready_r;
        idle_like_s  = (state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_FAULT);
        start_ok_s   = start & idle_like_s & loaded_r & ~accept_s;
        cycles_inc_s = cycles_r + 32'd1;
        state_nxt_s  = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start_ok_s) begin
                    state_nxt_s = S_REGINIT;
                end else if (accept_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_REGINIT: begin
                if (reg_addr_r == LAST_REG) begin
                    state_nxt_s = S_ARM;
                end else begin
                    state_nxt_s = S_REGINIT;
                end
            end
            S_ARM:    state_nxt_s = S_RUN;
            S_RUN: begin
                // HALT wins over the timeout on the same edge
                if (core_halted) begin
                    state_nxt_s = S_READ_A;
                end else if (cycles_inc_s >= TMO_CNT) begin
                    state_nxt_s = S_FAULT;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_READ_A: state_nxt_s = S_READ_D;
            S_READ_D: state_nxt_s = S_DONE;
            default:  state_nxt_s = S_IDLE;
        endcase
        if ((state_nxt_s == S_REGINIT) && (state_r == S_REGINIT)) begin
            reg_addr_nxt_s = reg_addr_r + 5'd1;
        end else begin
            reg_addr_nxt_s = 5'd0;
        end
    end

    // State, loaded flag and all registered outputs
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            loaded_r       <= 1'b0;
            ld_ready_r     <= 1'b1;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= {DATA_W{1'b0}};
            reg_we_r       <= 1'b0;
            reg_addr_r     <= 5'd0;
            reg_wdata_r    <= {DATA_W{1'b0}};
            core_pc_rst_r  <= 1'b0;
            core_run_r     <= 1'b0;
            busy_r         <= 1'b0;
            result_r       <= {DATA_W{1'b0}};
            result_valid_r <= 1'b0;
            timeout_err_r  <= 1'b0;
            cycles_r       <= 32'd0;
        end else begin
            state_r       <= state_nxt_s;
            ld_ready_r    <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_DONE) ||
                             (state_nxt_s == S_FAULT);
            busy_r        <= (state_nxt_s == S_REGINIT) || (state_nxt_s == S_ARM) ||
                             (state_nxt_s == S_RUN) || (state_nxt_s == S_READ_A) ||
                             (state_nxt_s == S_READ_D);
            mem_we_r      <= accept_s;
            reg_we_r      <= (state_nxt_s == S_REGINIT);
            reg_addr_r    <= reg_addr_nxt_s;
            reg_wdata_r   <= (REG_INIT_MODE != 0) ? {{(DATA_W-5){1'b0}}, reg_addr_nxt_s}
                                                  : {DATA_W{1'b0}};
            core_pc_rst_r <= (state_nxt_s == S_ARM);
            core_run_r    <= (state_nxt_s == S_RUN);

            if (accept_s) begin
                mem_addr_r  <= ld_addr;
                mem_wdata_r <= ld_data;
                loaded_r    <= ld_last;
            end else if ((state_r == S_RUN) && (state_nxt_s == S_READ_A)) begin
                mem_addr_r  <= RES_ADDR;
            end else begin
                mem_addr_r  <= mem_addr_r;
            end

            if (start_ok_s) begin
                cycles_r <= 32'd0;
            end else if ((state_r == S_RUN) && !core_halted && (cycles_r < TMO_CNT)) begin
                cycles_r <= cycles_inc_s;
            end else begin
                cycles_r <= cycles_r;
            end

            if (state_r == S_READ_D) begin
                result_r <= mem_rdata;
            end else begin
                result_r <= result_r;
            end

            if (start_ok_s || accept_s) begin
                result_valid_r <= 1'b0;
                timeout_err_r  <= 1'b0;
            end else begin
                result_valid_r <= result_valid_r | (state_r == S_READ_D);
                timeout_err_r  <= timeout_err_r | ((state_r == S_RUN) && (state_nxt_s == S_FAULT));
            end
        end
    end

    assign ld_ready     = ld_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign reg_we       = reg_we_r;
    assign reg_addr     = reg_addr_r;
    assign reg_wdata    = reg_wdata_r;
    assign core_pc_rst  = core_pc_rst_r;
    assign core_run     = core_run_r;
    assign busy         = busy_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign timeout_err  = timeout_err_r;
    assign cycles       = cycles_r;

endmodule

// File: tb/tb_mips_loader_monitor.sv
// Bench for mips_loader_monitor: memory + behavioural core stand-in, vector table,
// hand sequences for reset/timeout/ignored-start corners and a randomized run loop.
module tb_mips_loader_monitor;
    localparam int DW = 32, AW = 10, NR = 31, TMO = 64, RA = 198;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic          rst_n, ld_valid, ld_ready, ld_last, start, mem_we, reg_we;
    logic [AW-1:0] ld_addr, mem_addr;
    logic [DW-1:0] ld_data, mem_wdata, mem_rdata, reg_wdata, result;
    logic [4:0]    reg_addr;
    logic          core_pc_rst, core_run, core_halted, busy, result_valid, timeout_err;
    logic [31:0]   cycles;

    mips_loader_monitor #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR), .REG_INIT_MODE(1),
                          .RESULT_ADDR(RA), .TIMEOUT(TMO)) dut (
        .clk1(clk1), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .start(start),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .core_pc_rst(core_pc_rst), .core_run(core_run), .core_halted(core_halted),
        .busy(busy), .result(result), .result_valid(result_valid),
        .timeout_err(timeout_err), .cycles(cycles));

    int checks = 0;
    int errors = 0;

    function automatic int fact(input int n);
        int r = 1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    // Memory with 1-cycle read latency; the core stand-in halts after halt_after run
    // cycles and deposits fact(Mem[200]) at the result address.
    bit [31:0] mem [0:(1<<AW)-1];
    int        halt_after = 20;
    int        run_cnt;
    int        edge_cnt = 0;

    always @(posedge clk1) begin
        edge_cnt <= edge_cnt + 1;
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (rst_n && !core_pc_rst && core_run && !core_halted && (run_cnt + 1 == halt_after))
            mem[RA] <= 32'(fact(int'(mem[200])));
    end

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt     <= 0;
            core_halted <= 1'b0;
        end else if (core_pc_rst) begin
            run_cnt     <= 0;
            core_halted <= 1'b0;
        end else if (core_run && !core_halted) begin
            run_cnt <= run_cnt + 1;
            if (run_cnt + 1 == halt_after) core_halted <= 1'b1;
        end
    end

    // Observation logs sampled on the falling edge
    typedef struct { int cyc; int a; int d; } rw_t;
    rw_t  reg_q[$];
    int   pc_q[$];
    int   run_q[$];
    int   ncyc = 0;
    logic run_prev = 1'b0;

    always @(negedge clk1) begin
        ncyc <= ncyc + 1;
        run_prev <= core_run;
        if (reg_we) reg_q.push_back('{ncyc, int'(reg_addr), int'(reg_wdata)});
        if (core_pc_rst) pc_q.push_back(ncyc);
        if (core_run && !run_prev) run_q.push_back(ncyc);
    end

    int last_result = 0;

    task automatic chk_cleared(input string tag);
        chk({tag, "_ld_ready"}, ld_ready, 1);
        chk({tag, "_zero_outs"}, {mem_we, reg_we, core_pc_rst, core_run, busy,
                                  result_valid, timeout_err}, 0);
        chk({tag, "_cycles"}, cycles, 0);
        chk({tag, "_result"}, result, 0);
    endtask

    task automatic wait_end(input int t0, input int h, input int n);
        int lat;
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            if (result_valid || timeout_err) seen = 1;
        end
        if (!seen) chk("wait_end_timeout", 0, 1);
        lat = edge_cnt - t0;
        if (h < TMO) begin
            chk("latency_done", lat, h + NR + 4);
            chk("result_valid", result_valid, 1);
            chk("timeout_err_lo", timeout_err, 0);
            chk("result", result, fact(n));
            chk("cycles_done", cycles, h);
            last_result = fact(n);
        end else begin
            chk("latency_fault", lat, NR + 1 + TMO);
            chk("timeout_err", timeout_err, 1);
            chk("result_valid_lo", result_valid, 0);
            chk("result_kept", result, last_result);
            chk("cycles_sat", cycles, TMO);
        end
        chk("end_idle_flags", {busy, core_run, ld_ready}, 3'b001);
    endtask

    task automatic run_and_check(input int h, input int n);
        int t0;
        halt_after = h;
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = edge_cnt;
        wait_end(t0, h, n);
    endtask

    task automatic wait_run();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (core_run) seen = 1;
        end
        if (!seen) chk("wait_run_timeout", 0, 1);
    endtask

    typedef struct {
        logic v; logic [AW-1:0] a; logic [DW-1:0] d; logic last; logic st;
        logic e_we; logic [AW-1:0] e_addr; logic e_rdy; logic e_busy; logic e_regwe;
    } vec_t;
    vec_t vt[7];

    initial begin
        int t0, n, nb, cur_n;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0; start = 1'b0;
        #12;
        chk_cleared("reset");
        @(negedge clk1);
        rst_n = 1'b1;

        // Loads, ignored starts (not loaded / coincident beat), honoured start, beat in REGINIT
        vt[0] = '{1'b1, 10'd0,   32'd11, 1'b0, 1'b0, 1'b1, 10'd0,   1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 10'd1,   32'd22, 1'b0, 1'b1, 1'b1, 10'd1,   1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b1, 10'd200, 32'd7,  1'b1, 1'b1, 1'b1, 10'd200, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 10'd0,   32'd0,  1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 10'd0,   32'd0,  1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 1'b1, 1'b1};
        vt[5] = '{1'b1, 10'd5,   32'd99, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b0, 10'd0,   32'd0,  1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 1'b1, 1'b1};
        halt_after = 20;
        t0 = 0;
        for (int i = 0; i < 7; i++) begin
            ld_valid = vt[i].v; ld_addr = vt[i].a; ld_data = vt[i].d;
            ld_last = vt[i].last; start = vt[i].st;
            step();
            if (i == 4) t0 = edge_cnt;
            chk($sformatf("vec%0d_mem_we", i), mem_we, vt[i].e_we);
            if (vt[i].e_we) begin
                chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].e_addr);
                chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vt[i].d);
            end
            chk($sformatf("vec%0d_ld_ready", i), ld_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            chk($sformatf("vec%0d_reg_we", i), reg_we, vt[i].e_regwe);
        end
        ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
        wait_end(t0, 20, 7);
        cur_n = 7;

        // Register init sequence and ARM pulse ordering from that first run
        chk("reginit_count", reg_q.size(), NR);
        if (reg_q.size() >= NR) begin
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("reginit_addr%0d", k), reg_q[k].a, k);
                chk($sformatf("reginit_data%0d", k), reg_q[k].d, k);
                chk($sformatf("reginit_cyc%0d", k), reg_q[k].cyc - reg_q[0].cyc, k);
            end
            chk("pc_rst_count", pc_q.size(), 1);
            chk("run_rise_count", run_q.size(), 1);
            if (pc_q.size() == 1 && run_q.size() == 1) begin
                chk("pc_rst_after_reginit", pc_q[0] - reg_q[NR-1].cyc, 1);
                chk("run_after_pc_rst", run_q[0] - pc_q[0], 1);
            end
        end

        // Rerun without reload; start and a beat during RUN are ignored
        halt_after = 40;
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = edge_cnt;
        wait_run();
        repeat (5) step();
        start = 1'b1; ld_valid = 1'b1; ld_addr = 10'd3; ld_data = 32'd5;
        step();
        chk("run_start_busy", busy, 1);
        chk("run_ld_ready", ld_ready, 0);
        chk("run_no_mem_we", mem_we, 0);
        start = 1'b0; ld_valid = 1'b0;
        step();
        chk("run_no_mem_we2", mem_we, 0);
        wait_end(t0, 40, cur_n);

        // Timeout with the core never halting
        run_and_check(1000, cur_n);
        chk("fault_core_run", core_run, 0);

        // Asynchronous reset in the middle of a run
        halt_after = 1000;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_run();
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk_cleared("midrun_reset");
        @(negedge clk1);
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_after_reset_busy", busy, 0);
        step();
        chk("start_after_reset_reg_we", {busy, reg_we}, 0);

        // Randomized image loads and runs against the model
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, 10);
            if (it == 0 || $urandom_range(0, 2) != 0) begin
                nb = $urandom_range(1, 5);
                for (int b = 0; b <= nb; b++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        ld_valid = 1'b0;
                        step();
                        chk("gap_mem_we", mem_we, 0);
                    end
                    a = (b == nb) ? 10'd200 : 10'($urandom_range(0, 190));
                    d = (b == nb) ? 32'(n) : 32'($urandom);
                    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = (b == nb);
                    step();
                    chk("beat_mem_we", mem_we, 1);
                    chk("beat_mem_addr", mem_addr, a);
                    chk("beat_mem_wdata", mem_wdata, d);
                    if (b == 0) chk("beat_clears_flags", {result_valid, timeout_err}, 0);
                end
                ld_valid = 1'b0; ld_last = 1'b0;
                cur_n = n;
            end
            run_and_check($urandom_range(1, 90), cur_n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
